mips_div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the MIPS ALU; serves DIV/DIVU/MOD/MODU.
- Produces quotient and remainder with signed (MIPS DIV) or unsigned (DIVU) semantics, one quotient bit per clock.
- The ALU drives operands and sign select; the controller watches divdone and re-arms the unit by pulsing divrst low.

---
 rtl/mips_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_div_unit.sv
// ---------------------------------------------------------------------------
// mips_div_unit
//
// Multi-cycle restoring divider for the MIPS ALU (DIV/DIVU/MOD/MODU).
// After divrst is released, the first rising edge captures the operands. The
// next WIDTH edges each produce one quotient bit, MSB first. The last of
// those edges loads the sign-corrected quotient and remainder and raises
// divdone. The result then holds until divrst is pulled low again.
//
// Ports:
//   clk      in   rising-edge clock
//   divrst   in   asynchronous active-low reset; releasing it starts a division
//   a        in   [WIDTH-1:0] dividend
//   b        in   [WIDTH-1:0] divisor
//   signdiv  in   1 = signed (two's complement), 0 = unsigned
//   q        out  [WIDTH-1:0] quotient, registered, 0 until done
//   r        out  [WIDTH-1:0] remainder, registered, 0 until done
//   divdone  out  high while q/r hold a valid result
// ---------------------------------------------------------------------------
module mips_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             divrst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signdiv,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             divdone
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    // dvd starts as the dividend magnitude. Each step shifts one dividend bit
    // out of the top and one quotient bit in at the bottom, so by the end
    // it holds the quotient magnitude.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic             load_op;
    logic             step_op;
    logic             finish_op;
    logic             last_iter;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign last_iter = (count == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge divrst) begin
        if (!divrst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE is only left through reset.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = RUN;
            RUN:     state_next = last_iter ? DONE : RUN;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    // Datapath control decoded from the current state.
    always_comb begin
        load_op   = 1'b0;
        step_op   = 1'b0;
        finish_op = 1'b0;
        case (state)
            LOAD: load_op = 1'b1;
            RUN: begin
                step_op   = 1'b1;
                finish_op = last_iter;
            end
            default: ;
        endcase
    end

    // Operand magnitudes. -0x80000000 wraps back to 0x80000000. Read as
    // unsigned, that is the correct magnitude 2^31.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (signdiv) begin
            a_mag = a[WIDTH-1] ? -a : a;
            b_mag = b[WIDTH-1] ? -b : b;
        end
    end

    // One restoring step. The compare is WIDTH+1 bits wide because the
    // shifted-in bit can push the partial remainder past WIDTH bits. When
    // ge is set the true difference is below the divisor, so a WIDTH-bit
    // modular subtract is exact.
    always_comb begin
        rem_shift = {rem, dvd[WIDTH-1]};
        ge        = (rem_shift >= {1'b0, dvs});
        rem_next  = ge ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
        quot_mag  = {dvd[WIDTH-2:0], ge};
    end

    // Sign correction on the last step. With a zero divisor every step
    // subtracts nothing, so the quotient magnitude is all ones and the
    // remainder is |a|. Restoring the dividend's sign gives back a. The
    // quotient is forced to all ones so the dividend's sign cannot flip it.
    always_comb begin
        q_final = q_neg ? -quot_mag : quot_mag;
        r_final = r_neg ? -rem_next : rem_next;
        if (div_zero) begin
            q_final = '1;
        end
    end

    // Working registers and result registers. q/r remain zero until the
    // final step so that partial results are never visible.
    always_ff @(posedge clk or negedge divrst) begin
        if (!divrst) begin
            count    <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            q        <= '0;
            r        <= '0;
            divdone  <= 1'b0;
        end else begin
            if (load_op) begin
                count    <= '0;
                dvd      <= a_mag;
                dvs      <= b_mag;
                rem      <= '0;
                q_neg    <= signdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg    <= signdiv & a[WIDTH-1];
                div_zero <= (b == '0);
            end
            if (step_op) begin
                count <= count + CW'(1);
                dvd   <= quot_mag;
                rem   <= rem_next;
            end
            if (finish_op) begin
                q       <= q_final;
                r       <= r_final;
                divdone <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_div_unit
//
// Directed and random divisions on mips_div_unit. Expected quotient and
// remainder pairs are queued when an operation is started. They are popped
// and compared when divdone rises. Latency, hold behaviour and asynchronous
// abort are checked along the way.
// ---------------------------------------------------------------------------
module tb_mips_div_unit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;
    localparam int BUDGET  = 40;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
    } result_t;

    logic             clk = 1'b0;
    logic             divrst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signdiv;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             divdone;

    result_t expq[$];
    int      checks = 0;
    int      errors = 0;

    mips_div_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .divrst  (divrst),
        .a       (a),
        .b       (b),
        .signdiv (signdiv),
        .q       (q),
        .r       (r),
        .divdone (divdone)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference quotient/remainder from native operators plus the two
    // special cases the divider defines.
    function automatic result_t model(input logic [WIDTH-1:0] ma,
                                      input logic [WIDTH-1:0] mb,
                                      input logic msd);
        result_t res;
        if (mb == '0) begin
            res.q = '1;
            res.r = ma;
        end else if (msd && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = '0;
        end else if (msd) begin
            res.q = $signed(ma) / $signed(mb);
            res.r = $signed(ma) % $signed(mb);
        end else begin
            res.q = ma / mb;
            res.r = ma % mb;
        end
        return res;
    endfunction

    // Reset the unit, present operands, and queue the expected result.
    // Release reset and count edges until divdone rises or the budget runs
    // out. Then check latency and pop and compare the result. A nonzero
    // change_edge swaps in new operands after that edge.
    task automatic applyStimulus(input string tag,
                                 input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                 input logic tsd,
                                 input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                                 input int change_edge,
                                 input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
        result_t exp_res;
        result_t got;
        int      edges;
        divrst = 1'b0;
        a      = ta;
        b      = tb_v;
        signdiv = tsd;
        exp_res.q = eq;
        exp_res.r = er;
        expq.push_back(exp_res);
        @(negedge clk);
        @(negedge clk);
        divrst = 1'b1;
        edges = 0;
        while (edges < BUDGET) begin
            @(posedge clk);
            #1;
            edges++;
            if (change_edge != 0 && edges == change_edge) begin
                a = na;
                b = nb;
            end
            if (divdone === 1'b1) break;
            if (edges == 16) begin
                checkOutput({tag, " mid q"}, q, '0);
                checkOutput({tag, " mid r"}, r, '0);
            end
        end
        checkOutput({tag, " latency"}, WIDTH'(edges), WIDTH'(LATENCY));
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            got = expq.pop_front();
            checkOutput({tag, " q"}, q, got.q);
            checkOutput({tag, " r"}, r, got.r);
        end
    endtask

    initial begin
        result_t m;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rsd;

        divrst  = 1'b0;
        a       = '0;
        b       = '0;
        signdiv = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset q", q, '0);
        checkOutput("reset r", r, '0);
        checkOutput("reset divdone", {31'd0, divdone}, 32'd0);

        // Unsigned 100/7, then the result must hold while inputs wander.
        applyStimulus("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, '0, '0);
        a = 32'd5;
        b = 32'd1;
        signdiv = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("hold q", q, 32'd14);
        checkOutput("hold r", r, 32'd2);
        checkOutput("hold divdone", {31'd0, divdone}, 32'd1);

        // Reset while in DONE clears outputs without a clock edge.
        #2;
        divrst = 1'b0;
        #1;
        checkOutput("done abort q", q, '0);
        checkOutput("done abort r", r, '0);
        checkOutput("done abort divdone", {31'd0, divdone}, 32'd0);

        // Signed cases: the quotient truncates toward zero and the
        // remainder takes the dividend's sign.
        applyStimulus("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, '0, '0);
        applyStimulus("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0, '0, '0);

        // Signed overflow and the same operands read as unsigned.
        applyStimulus("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0, '0, '0);
        applyStimulus("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 0, '0, '0);

        // Divide by zero in both modes, including a negative signed dividend.
        applyStimulus("u_dz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 0, '0, '0);
        applyStimulus("s_dz", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 0, '0, '0);
        applyStimulus("s_dzneg", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 0, '0, '0);

        // Operands change after capture and must be ignored.
        applyStimulus("stable", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 5, 32'd999, 32'd3);

        // Abort mid-RUN, then a clean division.
        divrst  = 1'b0;
        a       = 32'd100;
        b       = 32'd7;
        signdiv = 1'b0;
        @(negedge clk);
        divrst = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        divrst = 1'b0;
        #1;
        checkOutput("run abort q", q, '0);
        checkOutput("run abort r", r, '0);
        checkOutput("run abort divdone", {31'd0, divdone}, 32'd0);
        applyStimulus("u9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 0, '0, '0);

        // Random operands checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = (i % 2 == 0) ? WIDTH'($urandom_range(1, 1000)) : $urandom;
            if (rb == '0) rb = 32'd3;
            rsd = (i >= 3);
            m = model(ra, rb, rsd);
            applyStimulus($sformatf("rand%0d", i), ra, rb, rsd, m.q, m.r, 0, '0, '0);
        end

        checkOutput("scoreboard drained", WIDTH'(expq.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
